// File: rtl/led_pwm_driver.sv
// PWM dimmer and blinker for a bank of LEDs driven from a PIO pattern, with an
// Avalon-MM slave holding control, duty, prescale and blink registers.
module led_pwm_driver #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pattern,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] led
);

  localparam logic [1:0]  ADDR_CTRL     = 2'd0;
  localparam logic [1:0]  ADDR_DUTY     = 2'd1;
  localparam logic [1:0]  ADDR_PRESCALE = 2'd2;
  localparam logic [1:0]  ADDR_BLINK    = 2'd3;
  localparam logic [7:0]  PWM_LAST      = 8'd254;
  localparam logic [7:0]  DUTY_FULL     = 8'd255;

  // Software-visible registers
  logic        enable_reg;
  logic        blink_en_reg;
  logic [7:0]  duty_reg;
  logic [15:0] prescale_reg;
  logic [7:0]  blink_reg;

  // Datapath state
  logic [15:0]      presc_cnt_reg, presc_cnt_next;
  logic [7:0]       pwm_cnt_reg, pwm_cnt_next;
  logic [7:0]       active_duty_reg, active_duty_next;
  logic [WIDTH-1:0] latch_reg, latch_next;
  logic [7:0]       blink_cnt_reg, blink_cnt_next;
  logic             phase_reg, phase_next;
  logic [WIDTH-1:0] led_reg, led_next;

  logic wr_en;
  logic tick;
  logic period_end;
  logic pwm_on;
  logic led_gate;
  logic unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_reg   <= 1'b1;
      blink_en_reg <= 1'b0;
      duty_reg     <= DUTY_FULL;
      prescale_reg <= 16'd0;
      blink_reg    <= 8'd0;
    end else if (wr_en) begin
      case (address)
        ADDR_CTRL: begin
          enable_reg   <= writedata[0];
          blink_en_reg <= writedata[1];
        end
        ADDR_DUTY:     duty_reg     <= writedata[7:0];
        ADDR_PRESCALE: prescale_reg <= writedata[15:0];
        default:       blink_reg    <= writedata[7:0];
      endcase
    end
  end

  // ">=" rather than "==" so that lowering PRESCALE below the running count
  // fires a tick on the next cycle instead of waiting for a 16-bit wrap.
  assign tick       = (presc_cnt_reg >= prescale_reg);
  assign period_end = tick && (pwm_cnt_reg == PWM_LAST);

  always_comb begin
    presc_cnt_next   = presc_cnt_reg;
    pwm_cnt_next     = pwm_cnt_reg;
    active_duty_next = active_duty_reg;
    latch_next       = latch_reg;
    blink_cnt_next   = blink_cnt_reg;
    phase_next       = phase_reg;
    if (!enable_reg) begin
      // Parked: counters idle and the shadows track their sources so the
      // first enabled period starts cleanly from pwm_cnt = 0.
      presc_cnt_next   = 16'd0;
      pwm_cnt_next     = 8'd0;
      blink_cnt_next   = 8'd0;
      phase_next       = 1'b1;
      active_duty_next = duty_reg;
      latch_next       = pattern;
    end else begin
      if (tick) begin
        presc_cnt_next = 16'd0;
        pwm_cnt_next   = (pwm_cnt_reg == PWM_LAST) ? 8'd0 : pwm_cnt_reg + 8'd1;
      end else begin
        presc_cnt_next = presc_cnt_reg + 16'd1;
      end
      if (period_end) begin
        active_duty_next = duty_reg;
        latch_next       = pattern;
        if (blink_cnt_reg == blink_reg) begin
          blink_cnt_next = 8'd0;
          phase_next     = ~phase_reg;
        end else begin
          blink_cnt_next = blink_cnt_reg + 8'd1;
        end
      end
    end
  end

  assign pwm_on   = (pwm_cnt_reg < active_duty_reg) || (active_duty_reg == DUTY_FULL);
  assign led_gate = enable_reg & pwm_on & (~blink_en_reg | phase_reg);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_led
      assign led_next[gi] = latch_reg[gi] & led_gate;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_reg   <= 16'd0;
      pwm_cnt_reg     <= 8'd0;
      active_duty_reg <= DUTY_FULL;
      latch_reg       <= '0;
      blink_cnt_reg   <= 8'd0;
      phase_reg       <= 1'b1;
      led_reg         <= '0;
    end else begin
      presc_cnt_reg   <= presc_cnt_next;
      pwm_cnt_reg     <= pwm_cnt_next;
      active_duty_reg <= active_duty_next;
      latch_reg       <= latch_next;
      blink_cnt_reg   <= blink_cnt_next;
      phase_reg       <= phase_next;
      led_reg         <= led_next;
    end
  end

  assign led = led_reg;

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:     readdata = {29'd0, phase_reg, blink_en_reg, enable_reg};
      ADDR_DUTY:     readdata = {24'd0, duty_reg};
      ADDR_PRESCALE: readdata = {16'd0, prescale_reg};
      default:       readdata = {24'd0, blink_reg};
    endcase
  end

endmodule
